// File: rtl/upg_loader.sv
// UART programmer back-end: parses framed segments into 32-bit memory write strobes.
// Optional status-byte echo FIFO is enabled with `define UPG_ECHO_EN.
module upg_loader #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
`ifdef UPG_ECHO_EN
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
`endif
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADDR_W:0]   upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CNT_L = 3'd1;
    localparam logic [2:0] S_CNT_H = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_SUM   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [15:0]       rem_q, rem_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              sel_q, sel_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        byte_q, byte_d;
    logic [7:0]        acc_q, acc_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              wen_q, wen_d;
    logic [ADDR_W:0]   adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        busy;
    logic        tmo_hit;
    logic [15:0] n_word;

    assign busy    = (state_q == S_CNT_L) || (state_q == S_CNT_H) ||
                     (state_q == S_DATA)  || (state_q == S_SUM);
    assign tmo_hit = busy && !rx_valid && (tmo_q == TMO_LAST);
    assign n_word  = {rx_data, cnt_lo_q};

`ifdef UPG_ECHO_EN
    logic       push, pop, full, drop;
    logic [7:0] push_byte;
    logic [7:0] fifo_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] fcnt_q;

    // Status events are mutually exclusive: a timeout cycle never carries an rx byte.
    assign push      = tmo_hit ||
                       (rx_valid && (state_q == S_SUM)) ||
                       (rx_valid && (state_q == S_IDLE) && (rx_data == 8'h45));
    assign push_byte = (tmo_hit || ((state_q == S_SUM) && (rx_data != acc_q))) ? 8'h15 : 8'h06;
    assign full      = (fcnt_q == 2'd2);
    assign pop       = (fcnt_q != 2'd0) && tx_ready;
    assign drop      = push && full && !pop;
    assign tx_valid  = (fcnt_q != 2'd0);
    assign tx_data   = fifo_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_q[0] <= 8'h00;
            fifo_q[1] <= 8'h00;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fcnt_q    <= 2'd0;
        end else begin
            if (push && !drop) begin
                fifo_q[wr_ptr_q] <= push_byte;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fcnt_q <= fcnt_q + {1'b0, push && !drop} - {1'b0, pop};
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        word_d   = word_q;
        byte_d   = byte_q;
        acc_d    = acc_q;
        tmo_d    = tmo_q;
        wen_d    = 1'b0;
        adr_d    = adr_q;
        dat_d    = dat_q;
        done_d   = done_q;
        err_d    = err_q;

        if (busy) begin
            tmo_d = rx_valid ? '0 : tmo_q + 1'b1;
        end

        if (tmo_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            byte_d  = 2'd0;
            tmo_d   = '0;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'h49) begin
                        sel_d   = 1'b0;
                        state_d = S_CNT_L;
                    end else if (rx_data == 8'h44) begin
                        sel_d   = 1'b1;
                        state_d = S_CNT_L;
                    end else if (rx_data == 8'h45) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_CNT_L: begin
                    cnt_lo_d = rx_data;
                    state_d  = S_CNT_H;
                end
                S_CNT_H: begin
                    if (n_word == 16'd0) begin
                        state_d = S_IDLE;
                    end else if (32'(n_word) > (32'd1 << ADDR_W)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rem_d   = n_word;
                        idx_d   = '0;
                        acc_d   = 8'h00;
                        byte_d  = 2'd0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    acc_d  = acc_q ^ rx_data;
                    byte_d = byte_q + 2'd1;
                    word_d = {rx_data, word_q[23:8]};
                    if (byte_q == 2'd3) begin
                        // Strobe registers one cycle after the 4th byte; index advances with it.
                        wen_d = 1'b1;
                        dat_d = {rx_data, word_q};
                        adr_d = {sel_q, idx_q};
                        idx_d = idx_q + 1'b1;
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_d = S_SUM;
                        end
                    end
                end
                S_SUM: begin
                    if (rx_data != acc_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: ;
            endcase
        end

`ifdef UPG_ECHO_EN
        if (drop) begin
            err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_lo_q <= 8'h00;
            rem_q    <= 16'd0;
            idx_q    <= '0;
            sel_q    <= 1'b0;
            word_q   <= 24'd0;
            byte_q   <= 2'd0;
            acc_q    <= 8'h00;
            tmo_q    <= '0;
            wen_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= 32'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            word_q   <= word_d;
            byte_q   <= byte_d;
            acc_q    <= acc_d;
            tmo_q    <= tmo_d;
            wen_q    <= wen_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign upg_rst_o  = done_q;
    assign upg_done_o = done_q;
    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign err_o      = err_q;
    assign busy_o     = busy;

endmodule

// File: doc/upg_loader.md
Name: upg_loader

Overview:
- UART programmer back-end. It sits directly upstream of the instruction-fetch stage's `upg_*` programming inputs.
- Consumes a byte stream from the existing UART receiver, parses a framed segment protocol and assembles little-endian 32-bit words.
- Drives one-cycle memory write strobes into instruction or data memory, then asserts done so the CPU regains the memories.

Parameters:
- ADDR_W, 14: word-address width of each memory.
- TIMEOUT_CYC, 1000000: idle-gap limit in cycles; applies inside a frame only.
- CNT_W, 20: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clock  input  1  programmer clock (10 MHz domain).
- reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  one-cycle pulse; rx_data is valid this cycle.
- rx_data  input  8  received byte.
- upg_rst_o  output  1  1 = CPU owns memories; low while loading.
- upg_wen_o  output  1  write strobe.
- upg_adr_o  output  ADDR_W+1  bit ADDR_W: 0 = instruction mem, 1 = data mem; low bits are the word index.
- upg_dat_o  output  32  write data.
- upg_done_o  output  1  load finished (sticky).
- err_o  output  1  sticky protocol/checksum/timeout error.
- busy_o  output  1  high while inside a frame.

Behaviour:
- Reset values: upg_rst_o=0, upg_done_o=0, err_o=0, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, busy_o=0, state=IDLE, all counters 0.
- Reset mid-operation aborts the frame immediately. No further write strobes are issued.
- State IDLE:
  - 0x49 ('I') selects instruction mem; 0x44 ('D') selects data mem. Both go to CNT_L.
  - 0x45 ('E') goes to DONE.
  - Any other byte is ignored; err_o is set.
- State CNT_L: latch the low byte of word count N.
- State CNT_H: latch the high byte of N.
  - N=0: go to IDLE.
  - N>2^ADDR_W: set err_o, go to IDLE.
  - Otherwise: clear word index and XOR accumulator, go to DATA.
- State DATA:
  - Bytes shift into the word little-endian: first byte is bits [7:0].
  - Every byte is XORed into the 8-bit accumulator.
  - The cycle after the 4th byte is accepted: upg_wen_o=1 for exactly one cycle, upg_dat_o = the word, upg_adr_o = {sel, index}. Then index increments.
  - After word N has been strobed, go to SUM.
  - An rx_valid arriving in the same cycle as the strobe is accepted; no byte is ever dropped.
  - The index never wraps because N is bounded.
- State SUM: the received byte must equal the accumulator.
  - Mismatch: set err_o. Already-written words are not rolled back.
  - Either way, return to IDLE.
- State DONE: upg_done_o=1 and upg_rst_o=1, held until reset. All further bytes are ignored.
- upg_dat_o and upg_adr_o hold their last values when upg_wen_o=0.
- Timeout:
  - In CNT_L, CNT_H, DATA or SUM, the counter increments on each cycle without rx_valid and clears on rx_valid.
  - On reaching TIMEOUT_CYC: set err_o, discard the partial word, go to IDLE.
  - The counter is frozen in IDLE and DONE.
- busy_o = state is CNT_L, CNT_H, DATA or SUM.
- err_o clears only on reset.

Optional Feature:
- Macro: UPG_ECHO_EN.
- Defined:
  - Adds ports tx_valid (output, 1), tx_data (output, 8) and tx_ready (input, 1).
  - At each SUM completion, queue one status byte: 0x06 on checksum match, 0x15 on mismatch. Also queue 0x15 on timeout and 0x06 on entry to DONE.
  - Queue is a 2-entry FIFO. A byte is held with tx_valid=1 until tx_ready=1.
  - A push when full drops the status byte and sets err_o.
- Undefined: no tx ports, no FIFO. Behaviour is otherwise identical.

Test Plan:
- Send 49 02 00 | 13 00 00 00 | 0C 00 00 00 | 1F -> two strobes: adr=0x0000 dat=0x00000013, then adr=0x0001 dat=0x0000000C; err_o=0.
- Send 44 01 00 | 78 56 34 12 | 08, then 45 -> one strobe adr=0x4000 dat=0x12345678; then upg_done_o=1, upg_rst_o=1; later bytes cause no strobes.
- Send the frame from the first test with final checksum byte 00 -> both strobes still issued; err_o=1 after SUM; state back to IDLE (verify by loading a next valid frame).
- Send 49 01 00 AA BB, then silence for TIMEOUT_CYC cycles -> no strobe, err_o=1, busy_o=0.
- Back-to-back rx_valid every cycle through a 3-word frame -> 3 strobes one cycle apart per 4 bytes, no lost bytes; assert reset mid-word -> all outputs return to reset values the next cycle.
- With UPG_ECHO_EN and tx_ready=0: send the first test's frame then 45 -> tx_data=0x06 held; release tx_ready -> 0x06 then 0x06 emitted; a third push while full sets err_o.
